// File: rtl/top_pkg.sv
// Shared types and constants for the dual transform pipeline.
package top_pkg;

    localparam int                 DATA_W     = 32;
    localparam int                 NUM_STAGES = 4;
    localparam logic [15:0]        LFSR_TAPS  = 16'hB400;
    localparam logic [DATA_W-1:0]  P2_XOR_K   = 32'h5A5A5A5A;
    localparam logic [DATA_W-1:0]  P2_ADD_K   = 32'd7;

    // One pipeline slot: valid flag travelling with its data word.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } stage_t;

    // Per-stage data transform selector.
    typedef enum logic [2:0] {
        XF_INC  = 3'd0,
        XF_MUL3 = 3'd1,
        XF_ADD7 = 3'd2,
        XF_XOR  = 3'd3,
        XF_PASS = 3'd4
    } xform_e;

    // Modular 32-bit transforms; x*3 is built as (x<<1)+x to avoid a multiplier.
    function automatic logic [DATA_W-1:0] apply_xform(input xform_e xf,
                                                      input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        case (xf)
            XF_INC:  r = x + DATA_W'(1);
            XF_MUL3: r = (x << 1) + x;
            XF_ADD7: r = x + P2_ADD_K;
            XF_XOR:  r = x ^ P2_XOR_K;
            default: r = x;
        endcase
        return r;
    endfunction

    // Transform used by stage idx (1..NUM_STAGES) of pipeline 2.
    function automatic xform_e p2_xform(input int idx);
        xform_e r;
        case (idx)
            1:       r = XF_MUL3;
            2:       r = XF_ADD7;
            3:       r = XF_XOR;
            default: r = XF_PASS;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/top_pipe_stage.sv
// One pipeline register: async clear, hold on stall, fixed data transform.
module pipe_stage
    import top_pkg::*;
#(
    parameter xform_e XFORM = XF_PASS
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   stall_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t stage_q;
    stage_t stage_d;

    // Next slot: valid passes through, transform applied whether or not valid.
    always_comb begin
        stage_d      = d_i;
        stage_d.data = apply_xform(XFORM, d_i.data);
    end

    // Slot register; frozen while the global stall is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else if (!stall_i) begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/top.sv
// Two independent 5-register pipelines sharing an LFSR-driven global stall.
module top
    import top_pkg::*;
#(
    parameter bit          STALL_EN  = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic              out_valid_1,
    output logic              out_valid_2
);

    // An all-zero seed would lock the LFSR at zero forever.
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("top: LFSR_SEED must be nonzero");
    end

    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_d;
    logic              stall;
    logic [DATA_W-1:0] cnt1_q;
    logic [DATA_W-1:0] cnt1_d;
    logic [DATA_W-1:0] cnt2_q;
    logic [DATA_W-1:0] cnt2_d;
    stage_t            p1_s0_q;
    stage_t            p2_s0_q;
    stage_t            p1_stg [0:NUM_STAGES];
    stage_t            p2_stg [0:NUM_STAGES];

    // Galois right-shift step: feedback bit is the outgoing LSB.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    // Stall generator free-runs, independent of the stall it produces.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Decoded from a register only, so no input reaches the outputs combinationally.
    assign stall = STALL_EN && (lfsr_q[1:0] == 2'b00);

    assign cnt1_d = cnt1_q + DATA_W'(1);
    assign cnt2_d = cnt2_q + DATA_W'(2);

    // Sources: capture the running count as a new valid item, then advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            p1_s0_q <= '0;
            p2_s0_q <= '0;
        end else if (!stall) begin
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            p1_s0_q <= '{valid: 1'b1, data: cnt1_q};
            p2_s0_q <= '{valid: 1'b1, data: cnt2_q};
        end
    end

    assign p1_stg[0] = p1_s0_q;
    assign p2_stg[0] = p2_s0_q;

    for (genvar i = 1; i <= NUM_STAGES; i++) begin : g_stage
        pipe_stage #(.XFORM(XF_INC)) u_p1 (
            .clk_i   (clk),
            .rst_i   (reset),
            .stall_i (stall),
            .d_i     (p1_stg[i-1]),
            .q_o     (p1_stg[i])
        );
        pipe_stage #(.XFORM(p2_xform(i))) u_p2 (
            .clk_i   (clk),
            .rst_i   (reset),
            .stall_i (stall),
            .d_i     (p2_stg[i-1]),
            .q_o     (p2_stg[i])
        );
    end

    // An item is reported only in the cycle it leaves the last stage.
    assign out_data_1  = p1_stg[NUM_STAGES].data;
    assign out_data_2  = p2_stg[NUM_STAGES].data;
    assign out_valid_1 = p1_stg[NUM_STAGES].valid & ~stall;
    assign out_valid_2 = p2_stg[NUM_STAGES].valid & ~stall;

endmodule

// File: tb/tb_top.sv
// Directed bench for top: one stall-free and one stalling instance side by side.
module tb_top;

    logic        clk;
    logic        reset;
    logic [31:0] ns_d1, ns_d2, st_d1, st_d2;
    logic        ns_v1, ns_v2, st_v1, st_v2;

    int vecs        = 0;
    int miscompares = 0;

    top #(.STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) dut_ns (
        .clk         (clk),
        .reset       (reset),
        .out_data_1  (ns_d1),
        .out_data_2  (ns_d2),
        .out_valid_1 (ns_v1),
        .out_valid_2 (ns_v2)
    );

    top #(.STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) dut_st (
        .clk         (clk),
        .reset       (reset),
        .out_data_1  (st_d1),
        .out_data_2  (st_d2),
        .out_valid_1 (st_v1),
        .out_valid_2 (st_v2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference for pipeline 2: ((src*3)+7) ^ 5A5A5A5A, pass-through last stage.
    function automatic logic [31:0] p2m(input logic [31:0] s);
        logic [31:0] t;
        t = s * 32'd3;
        t = t + 32'd7;
        return t ^ 32'h5A5A5A5A;
    endfunction

    initial begin
        logic [31:0] ns_next;
        logic [31:0] st_exp1;
        logic [31:0] st_src2;
        bit          st_seen;
        int          st_cycles;
        int          st_stalls;
        bit          frac_ok;

        reset   = 1'b1;
        ns_next = 32'd4;
        st_exp1 = 32'd4;
        st_src2 = 32'd0;
        st_seen = 1'b0;
        st_cycles = 0;
        st_stalls = 0;

        repeat (3) @(negedge clk);
        check("rst_ns_d1", ns_d1, 32'd0);
        check("rst_ns_d2", ns_d2, 32'd0);
        check("rst_ns_v1", 32'(ns_v1), 32'd0);
        check("rst_ns_v2", 32'(ns_v2), 32'd0);
        check("rst_st_v1", 32'(st_v1), 32'd0);
        check("rst_st_d1", st_d1, 32'd0);
        reset = 1'b0;

        // Long run: stall-free latency/stream checks plus stalled-stream scoreboard.
        for (int n = 1; n <= 65535; n++) begin
            step();
            if (n < 5) begin
                check("lat_ns_v1", 32'(ns_v1), 32'd0);
                check("lat_ns_v2", 32'(ns_v2), 32'd0);
            end else begin
                check("ns_v1", 32'(ns_v1), 32'd1);
                if (n < 105) begin
                    check("ns_d1", ns_d1, ns_next);
                    check("ns_d2", ns_d2, p2m(32'(2 * (n - 5))));
                    check("ns_v2", 32'(ns_v2), 32'd1);
                end
                ns_next = ns_next + 32'd1;
            end

            check("st_v_eq", 32'(st_v1), 32'(st_v2));
            if (st_v1) begin
                check("st_d1", st_d1, st_exp1);
                check("st_d2", st_d2, p2m(st_src2));
                st_exp1 = st_exp1 + 32'd1;
                st_src2 = st_src2 + 32'd2;
                st_seen = 1'b1;
            end else if (st_seen) begin
                st_stalls++;
            end
            if (st_seen) st_cycles++;
        end
        check("st_seen", 32'(st_seen), 32'd1);
        frac_ok = (st_cycles > 1000) && (st_stalls * 100 >= st_cycles * 23) &&
                  (st_stalls * 100 <= st_cycles * 27);
        check("st_frac", 32'(frac_ok), 32'd1);

        // Counter wrap: overwrite pipeline-1 count between edges.
        force dut_ns.cnt1_q = 32'hFFFFFFFE;
        #1;
        release dut_ns.cnt1_q;
        for (int k = 0; k < 4; k++) begin
            step();
            check("wrap_old_v", 32'(ns_v1), 32'd1);
            check("wrap_old_d", ns_d1, ns_next);
            ns_next = ns_next + 32'd1;
        end
        for (int k = 0; k < 4; k++) begin
            step();
            check("wrap_v", 32'(ns_v1), 32'd1);
            check("wrap_d", ns_d1, 32'd2 + 32'(k));
        end

        // Asynchronous reset mid-stream, asserted and released between edges.
        #2;
        reset = 1'b1;
        #1;
        check("arst_d1", ns_d1, 32'd0);
        check("arst_d2", ns_d2, 32'd0);
        check("arst_v1", 32'(ns_v1), 32'd0);
        check("arst_v2", 32'(ns_v2), 32'd0);
        check("arst_st_v1", 32'(st_v1), 32'd0);
        step();
        step();
        check("arst_hold_v1", 32'(ns_v1), 32'd0);
        check("arst_hold_d1", ns_d1, 32'd0);
        reset = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            check("rlat_v1", 32'(ns_v1), 32'd0);
        end
        step();
        check("rfirst_v1", 32'(ns_v1), 32'd1);
        check("rfirst_d1", ns_d1, 32'd4);
        check("rfirst_d2", ns_d2, 32'h5A5A5A5D);
        step();
        check("rsecond_d1", ns_d1, 32'd5);
        check("rsecond_d2", ns_d2, 32'h5A5A5A57);
        check("rsecond_st_eq", 32'(st_v1), 32'(st_v2));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
